// File: rtl/riscv_imem_pkg.sv
// Shared definitions for the instruction-memory loader/arbiter slice.
//   state_e         : boot sequencing states (load image, settle, run)
//   NopInstr        : instruction substituted on a faulting fetch (addi x0,x0,0)
//   is_word_aligned : true when a byte address sits on a 4-byte boundary
package riscv_imem_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StDrain,
    StRun
  } state_e;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/imem_load_seq.sv
// Load sequencer: byte write-address counter, loaded-byte count and overflow tracking.
//   clk, reset    : clock / asynchronous active-high reset
//   clear         : restart counting from address 0 and clear the error flag
//   accept        : a loader byte is being written this cycle
//   last          : the accepted byte is the final byte of the image
//   waddr         : address the next accepted byte is written to
//   loaded_bytes  : bytes written by the current/last load, saturating at DEPTH
//   load_err      : sticky, image did not fit in DEPTH bytes
//   overflow      : combinational, this accepted byte fills memory with no ld_last
module imem_load_seq #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          accept,
  input  logic          last,
  output logic [AW-1:0] waddr,
  output logic [AW:0]   loaded_bytes,
  output logic          load_err,
  output logic          overflow
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW:0]   MaxCount = (AW + 1)'(DEPTH);

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   loaded_q, loaded_d;
  logic          err_q, err_d;

  always_comb begin
    overflow = accept && !last && (waddr_q == LastAddr);
    waddr_d  = waddr_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (clear) begin
      waddr_d  = '0;
      loaded_d = '0;
      err_d    = 1'b0;
    end else if (accept) begin
      waddr_d = waddr_q + 1'b1;
      if (loaded_q != MaxCount) begin
        loaded_d = loaded_q + 1'b1;
      end
      if (overflow) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr_q  <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign waddr        = waddr_q;
  assign loaded_bytes = loaded_q;
  assign load_err     = err_q;

endmodule

// File: rtl/imem_load_arbiter.sv
// Instruction-memory owner: loads the byte-wide memory from a byte stream at boot or on reload,
// then hands it to the fetch stage (1-cycle latency, one request per cycle).
//   clk, reset        : clock / asynchronous active-high reset
//   reload            : abandon current activity and restart loading at address 0
//   ld_valid/ld_ready : loader byte handshake; ld_byte data, ld_last marks final byte
//   fetch_req/addr    : fetch request and byte address
//   fetch_valid/instr : registered response; fetch_fault flags misaligned/out-of-range
//   core_stall        : pipeline must hold PC while not running
//   load_err          : sticky image overflow; loaded_bytes byte count of the load
//   mem_*             : external memory write port and combinational word read port
module imem_load_arbiter
  import riscv_imem_pkg::*;
#(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned AW           = $clog2(DEPTH),
  parameter logic [31:0] NOP_INSTR    = NopInstr,
  parameter bit          START_IN_RUN = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reload,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_fault,
  output logic          core_stall,
  output logic          load_err,
  output logic [AW:0]   loaded_bytes,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata
);

  localparam logic [31:0] LastWordAddr = 32'(DEPTH - 4);
  localparam state_e      ResetState   = START_IN_RUN ? StRun : StLoad;

  state_e        state_q, state_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          fetch_fault_q, fetch_fault_d;
  logic [31:0]   fetch_instr_q, fetch_instr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          ld_accept, fetch_accept, fetch_bad, seq_overflow;
  logic [AW-1:0] waddr;

  imem_load_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_load_seq (
    .clk         (clk),
    .reset       (reset),
    .clear       (reload),
    .accept      (ld_accept),
    .last        (ld_last),
    .waddr       (waddr),
    .loaded_bytes(loaded_bytes),
    .load_err    (load_err),
    .overflow    (seq_overflow)
  );

  // Handshake, memory ports and state sequencing.
  always_comb begin
    ld_ready     = (state_q == StLoad);
    // reload wins: a byte offered alongside it is swallowed without a write
    ld_accept    = ld_ready && ld_valid && !reload;
    fetch_accept = (state_q == StRun) && fetch_req && !reload;
    fetch_bad    = !is_word_aligned(fetch_addr) || (fetch_addr > LastWordAddr);
    core_stall   = (state_q != StRun);

    mem_we    = ld_accept;
    mem_waddr = waddr;
    mem_wdata = ld_byte;

    // Read address only moves for a good fetch; faults leave the memory untouched
    raddr_d = raddr_q;
    if (fetch_accept && !fetch_bad) begin
      raddr_d = fetch_addr[AW-1:0];
    end
    mem_raddr = raddr_d;

    state_d = state_q;
    case (state_q)
      StLoad:  if (ld_accept && (ld_last || seq_overflow)) state_d = StDrain;
      StDrain: state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StLoad;
    endcase
    if (reload) begin
      state_d = StLoad;
    end
  end

  // Fetch response next-state, kept apart from the read-address logic above.
  always_comb begin
    fetch_valid_d = fetch_accept;
    fetch_fault_d = fetch_accept && fetch_bad;
    fetch_instr_d = fetch_instr_q;
    if (fetch_accept) begin
      fetch_instr_d = fetch_bad ? NOP_INSTR : mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ResetState;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_instr_q <= NOP_INSTR;
      raddr_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_instr_q <= fetch_instr_d;
      raddr_q       <= raddr_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_instr = fetch_instr_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset, reload, ld_valid, ld_last, fetch_req;
  logic [7:0]    ld_byte;
  logic [31:0]   fetch_addr;
  logic          ld_ready, fetch_valid, fetch_fault, core_stall, load_err, mem_we;
  logic [31:0]   fetch_instr, mem_rdata;
  logic [AW:0]   loaded_bytes;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [7:0]    mem_wdata;

  // second instance: boots straight into RUN with a preloaded memory
  logic          f2_req;
  logic [31:0]   f2_addr;
  logic          d2_ld_ready, d2_fetch_valid, d2_fetch_fault, d2_core_stall, d2_load_err, d2_mem_we;
  logic [31:0]   d2_fetch_instr, mem2_rdata;
  logic [AW:0]   d2_loaded_bytes;
  logic [AW-1:0] d2_mem_waddr, d2_mem_raddr;
  logic [7:0]    d2_mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_load_arbiter #(.DEPTH(DEPTH), .START_IN_RUN(1'b0)) dut (
    .clk(clk), .reset(reset), .reload(reload), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .core_stall(core_stall), .load_err(load_err), .loaded_bytes(loaded_bytes), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  imem_load_arbiter #(.DEPTH(DEPTH), .START_IN_RUN(1'b1)) dut_run (
    .clk(clk), .reset(reset), .reload(1'b0), .ld_valid(1'b0), .ld_ready(d2_ld_ready),
    .ld_byte(8'h00), .ld_last(1'b0), .fetch_req(f2_req), .fetch_addr(f2_addr),
    .fetch_valid(d2_fetch_valid), .fetch_instr(d2_fetch_instr), .fetch_fault(d2_fetch_fault),
    .core_stall(d2_core_stall), .load_err(d2_load_err), .loaded_bytes(d2_loaded_bytes),
    .mem_we(d2_mem_we), .mem_waddr(d2_mem_waddr), .mem_wdata(d2_mem_wdata),
    .mem_raddr(d2_mem_raddr), .mem_rdata(mem2_rdata)
  );

  // External memory arrays
  logic [7:0] mem  [DEPTH];
  logic [7:0] mem2 [DEPTH];

  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

  always_comb begin
    mem_rdata  = {mem[mem_raddr], mem[mem_raddr + 8'd1], mem[mem_raddr + 8'd2],
                  mem[mem_raddr + 8'd3]};
    mem2_rdata = {mem2[d2_mem_raddr], mem2[d2_mem_raddr + 8'd1], mem2[d2_mem_raddr + 8'd2],
                  mem2[d2_mem_raddr + 8'd3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase flags: neither set = loading, m_drain = settle cycle, m_run = serving fetches.
  bit          m_run, m_drain, m_err, m_fv, m_ff;
  int          m_waddr, m_loaded, m_raddr;
  logic [31:0] m_instr;
  logic [7:0]  img [DEPTH];

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a > 32'(DEPTH - 4));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_fv = 1'b0; m_ff = 1'b0;
      m_waddr = 0; m_loaded = 0; m_raddr = 0; m_instr = NOP;
    end else if (reload) begin
      m_run = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_fv = 1'b0; m_ff = 1'b0;
      m_waddr = 0; m_loaded = 0;
    end else if (m_run) begin
      m_fv = fetch_req;
      m_ff = fetch_req && is_bad(fetch_addr);
      if (fetch_req) begin
        if (is_bad(fetch_addr)) m_instr = NOP;
        else begin
          int a;
          a = int'(fetch_addr);
          m_instr = {img[a], img[a+1], img[a+2], img[a+3]};
          m_raddr = a;
        end
      end
    end else if (m_drain) begin
      m_drain = 1'b0; m_run = 1'b1; m_fv = 1'b0; m_ff = 1'b0;
    end else begin
      m_fv = 1'b0; m_ff = 1'b0;
      if (ld_valid) begin
        img[m_waddr] = ld_byte;
        if (ld_last) m_drain = 1'b1;
        else if (m_waddr == DEPTH - 1) begin
          m_err = 1'b1; m_drain = 1'b1;
        end
        m_waddr = m_waddr + 1;
        if (m_loaded < DEPTH) m_loaded = m_loaded + 1;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit c_loading, c_we;
  always begin
    @(negedge clk);
    #2;
    c_loading = !m_run && !m_drain;
    c_we      = c_loading && ld_valid && !reload;
    check("ld_ready", 32'(ld_ready), 32'(c_loading));
    check("mem_we", 32'(mem_we), 32'(c_we));
    if (c_we) begin
      check("mem_waddr", 32'(mem_waddr), 32'(m_waddr % DEPTH));
      check("mem_wdata", 32'(mem_wdata), 32'(ld_byte));
    end
    check("core_stall", 32'(core_stall), 32'(!m_run));
    if (m_run && fetch_req && !reload && !is_bad(fetch_addr))
      check("mem_raddr", 32'(mem_raddr), fetch_addr % DEPTH);
    else
      check("mem_raddr_hold", 32'(mem_raddr), 32'(m_raddr));
    check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    check("fetch_fault", 32'(fetch_fault), 32'(m_ff));
    check("fetch_instr", fetch_instr, m_instr);
    check("load_err", 32'(load_err), 32'(m_err));
    check("loaded_bytes", 32'(loaded_bytes), 32'(m_loaded));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  logic [7:0] boot_img [8];

  initial begin
    boot_img[0] = 8'h00; boot_img[1] = 8'h31; boot_img[2] = 8'h00; boot_img[3] = 8'hB3;
    boot_img[4] = 8'h00; boot_img[5] = 8'h20; boot_img[6] = 8'h01; boot_img[7] = 8'h13;
    mem2[0] = 8'hDE; mem2[1] = 8'hAD; mem2[2] = 8'hBE; mem2[3] = 8'hEF;
    reset = 1'b0; reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
    fetch_req = 1'b0; fetch_addr = 32'h0; f2_req = 1'b0; f2_addr = 32'h0;
    #1 reset = 1'b1;
    #3 check("rst_stall", 32'(core_stall), 32'd1);
    check("rst_instr", fetch_instr, NOP);
    check("rst_loaded", 32'(loaded_bytes), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Boot image load, with the preloaded instance fetching in its first cycle
    f2_req = 1'b1; f2_addr = 32'h0;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_byte = boot_img[i]; ld_last = (i == 7);
      #3;
      check("t1_we", 32'(mem_we), 32'd1);
      check("t1_waddr", 32'(mem_waddr), 32'(i));
      if (i == 0) check("t6_nostall", 32'(d2_core_stall), 32'd0);
      if (i == 1) begin
        check("t6_valid", 32'(d2_fetch_valid), 32'd1);
        check("t6_instr", d2_fetch_instr, 32'hDEADBEEF);
      end
      @(negedge clk);
      f2_req = 1'b0;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #3 check("t1_drain_stall", 32'(core_stall), 32'd1);
    check("t1_drain_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    #3 check("t1_run", 32'(core_stall), 32'd0);
    check("t1_loaded", 32'(loaded_bytes), 32'd8);

    // Back-to-back fetches
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    fetch_addr = 32'd4;
    #3 check("t2_v0", 32'(fetch_valid), 32'd1);
    check("t2_i0", fetch_instr, 32'h003100B3);
    @(negedge clk);
    fetch_req = 1'b0;
    #3 check("t2_v1", 32'(fetch_valid), 32'd1);
    check("t2_i1", fetch_instr, 32'h00200113);
    @(negedge clk);
    #3 check("t2_idle", 32'(fetch_valid), 32'd0);
    check("t2_hold", fetch_instr, 32'h00200113);

    // Faulting fetches: misaligned, past end, upper bits set
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'd2;
    #3 check("t3_raddr_a", 32'(mem_raddr), 32'd4);
    @(negedge clk);
    fetch_addr = 32'd253;
    #3 check("t3_f0", 32'(fetch_fault), 32'd1);
    check("t3_i0", fetch_instr, NOP);
    check("t3_raddr_b", 32'(mem_raddr), 32'd4);
    @(negedge clk);
    fetch_addr = 32'h1000_0000;
    #3 check("t3_f1", 32'(fetch_fault), 32'd1);
    @(negedge clk);
    fetch_addr = 32'd252;
    #3 check("t3_f2", 32'(fetch_fault), 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    #3 check("t3_edge_ok", 32'(fetch_fault), 32'd0);

    // Overflowing image: 257 bytes, none marked last
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    for (int i = 0; i < 257; i++) begin
      ld_valid = 1'b1; ld_byte = 8'(i) ^ 8'h5A; ld_last = 1'b0;
      #3;
      if (i == 128) check("t4_mid_count", 32'(loaded_bytes), 32'd128);
      if (i == 255) check("t4_ready_255", 32'(ld_ready), 32'd1);
      if (i == 256) begin
        check("t4_ready_off", 32'(ld_ready), 32'd0);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_count", 32'(loaded_bytes), 32'd256);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #3 check("t4_run", 32'(core_stall), 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'd252;
    @(negedge clk);
    fetch_req = 1'b0;
    #3 check("t4_top_word", fetch_instr, 32'hA6A7A4A5);

    // reload in the middle of a fetch stream
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    fetch_addr = 32'd4;
    @(negedge clk);
    fetch_addr = 32'd8; reload = 1'b1;
    @(negedge clk);
    reload = 1'b0; fetch_req = 1'b0;
    ld_valid = 1'b1; ld_byte = 8'h77; ld_last = 1'b0;
    #3 check("t5_valid", 32'(fetch_valid), 32'd0);
    check("t5_stall", 32'(core_stall), 32'd1);
    check("t5_err", 32'(load_err), 32'd0);
    check("t5_waddr", 32'(mem_waddr), 32'd0);
    // reload while loading swallows the byte offered with it
    @(negedge clk);
    ld_byte = 8'h88; reload = 1'b1;
    #3 check("t5_rl_we", 32'(mem_we), 32'd0);
    check("t5_rl_count", 32'(loaded_bytes), 32'd1);
    @(negedge clk);
    reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_byte = 8'h11 * 8'(i + 1); ld_last = (i == 3);
      #3 if (i == 0) check("t5_restart", 32'(mem_waddr), 32'd0);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    fetch_req = 1'b0;
    #3 check("t5_reloaded", fetch_instr, 32'h11223344);

    // Asynchronous reset in the middle of a load
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0; ld_valid = 1'b1; ld_byte = 8'hC0;
    @(negedge clk);
    ld_byte = 8'hC1;
    #4 reset = 1'b1;
    #1 check("t7_count", 32'(loaded_bytes), 32'd0);
    check("t7_stall", 32'(core_stall), 32'd1);
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #3 check("t7_run_inst", 32'(d2_core_stall), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
